// File: rtl/padded_window_reader.sv
// padded_window_reader
// Captures three zero-padded rows per colour channel on a start request and
// streams every 3x3 window (left column 0 .. ROW_PIX-3) over a valid/ready
// handshake, then pulses done for one cycle.
//
// Ports
//   clk, reset            : clock and asynchronous active-high reset
//   en                    : block enable; low synchronously clears the block
//   start                 : one-cycle capture/begin request (honoured in IDLE)
//   {R,G,B}_row{0,1,2}    : padded rows, pixel 0 in the most significant PIX_W bits
//   win_ready             : downstream accepts the current window
//   win_valid             : window outputs and col are valid
//   R_win, G_win, B_win   : 3x3 window per channel, row-major, MSB first
//   col                   : left column index of the current window
//   busy                  : capture held or stream in progress
//   done                  : one-cycle pulse after the last window is accepted
module padded_window_reader #(
  parameter int unsigned ROW_PIX = 418,
  parameter int unsigned PIX_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       start,
  input  logic [ROW_PIX*PIX_W-1:0]   R_row0,
  input  logic [ROW_PIX*PIX_W-1:0]   G_row0,
  input  logic [ROW_PIX*PIX_W-1:0]   B_row0,
  input  logic [ROW_PIX*PIX_W-1:0]   R_row1,
  input  logic [ROW_PIX*PIX_W-1:0]   G_row1,
  input  logic [ROW_PIX*PIX_W-1:0]   B_row1,
  input  logic [ROW_PIX*PIX_W-1:0]   R_row2,
  input  logic [ROW_PIX*PIX_W-1:0]   G_row2,
  input  logic [ROW_PIX*PIX_W-1:0]   B_row2,
  input  logic                       win_ready,
  output logic                       win_valid,
  output logic [9*PIX_W-1:0]         R_win,
  output logic [9*PIX_W-1:0]         G_win,
  output logic [9*PIX_W-1:0]         B_win,
  output logic [8:0]                 col,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned ROW_W  = ROW_PIX * PIX_W;
  localparam int unsigned TAP_W  = 3 * PIX_W;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned SH_W   = $clog2(ROW_W);
  localparam int unsigned N_ROWS = 9;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_PIX - 3);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [COL_W-1:0]  r_col;
  logic [COL_W-1:0]  w_col_nxt;
  logic              r_valid;
  logic              r_done;
  logic              r_busy;

  // Captured rows, ordered R0,R1,R2,G0,G1,G2,B0,B1,B2
  logic [ROW_W-1:0]  r_rows     [N_ROWS];
  logic [ROW_W-1:0]  w_rows_nxt [N_ROWS];
  logic [ROW_W-1:0]  w_in       [N_ROWS];

  assign w_in[0] = R_row0;
  assign w_in[1] = R_row1;
  assign w_in[2] = R_row2;
  assign w_in[3] = G_row0;
  assign w_in[4] = G_row1;
  assign w_in[5] = G_row2;
  assign w_in[6] = B_row0;
  assign w_in[7] = B_row1;
  assign w_in[8] = B_row2;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < N_ROWS; i++) r_rows[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_valid <= (w_state_nxt == ST_STREAM);
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      for (int i = 0; i < N_ROWS; i++) r_rows[i] <= w_rows_nxt[i];
    end
  end

  // Next-state, column and capture logic; en low overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    for (int i = 0; i < N_ROWS; i++) w_rows_nxt[i] = r_rows[i];

    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_col_nxt   = '0;
      for (int i = 0; i < N_ROWS; i++) w_rows_nxt[i] = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_ROWS; i++) w_rows_nxt[i] = w_in[i];
            w_col_nxt   = '0;
            w_state_nxt = ST_STREAM;
          end
        end
        ST_STREAM: begin
          // win_valid is high throughout STREAM, so ready alone marks a transfer
          if (win_ready) begin
            if (r_col == LAST_COL) begin
              w_col_nxt   = '0;
              w_state_nxt = ST_DONE;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Window taps: shift the column to the top, then take three pixels
  logic [SH_W-1:0]  w_shamt;
  logic [TAP_W-1:0] w_tap [N_ROWS];

  assign w_shamt = SH_W'(r_col) * SH_W'(PIX_W);

  for (genvar i = 0; i < N_ROWS; i++) begin : g_tap
    logic [ROW_W-1:0] w_sh;
    assign w_sh     = r_rows[i] << w_shamt;
    assign w_tap[i] = w_sh[ROW_W-1 -: TAP_W];
  end

  assign R_win     = {w_tap[0], w_tap[1], w_tap[2]};
  assign G_win     = {w_tap[3], w_tap[4], w_tap[5]};
  assign B_win     = {w_tap[6], w_tap[7], w_tap[8]};
  assign col       = r_col;
  assign win_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/padded_window_reader.md
PADDED_WINDOW_READER -- requirements
Module: padded_window_reader

Interface
REQ-001 SHALL have parameter ROW_PIX, default 418, meaning pixels per padded row including the two zero-pad columns.
REQ-002 SHALL have parameter PIX_W, default 8, meaning bits per pixel per channel.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  meaning block enable; low synchronously clears the block.
REQ-006 SHALL have port start  input  1  meaning a one-cycle request to capture the row inputs and begin streaming.
REQ-007 SHALL have ports R_row0/G_row0/B_row0, R_row1/G_row1/B_row1 and R_row2/G_row2/B_row2  input  ROW_PIX*PIX_W (3344)  meaning the three padded rows per channel, with pixel j at bits [W-1-PIX_W*j -: PIX_W] (pixel 0 is the MSB byte).
REQ-008 SHALL have port win_ready  input  1  meaning the downstream block accepts the current window.
REQ-009 SHALL have port win_valid  output  1  meaning R_win/G_win/B_win and col hold a valid window.
REQ-010 SHALL have ports R_win/G_win/B_win  output  9*PIX_W (72)  meaning one 3x3 window per channel.
REQ-011 SHALL have port col  output  9  meaning the left column index of the current window.
REQ-012 SHALL have port busy  output  1  meaning a capture is held or streaming is in progress.
REQ-013 SHALL have port done  output  1  meaning a one-cycle pulse after the last window is accepted.

Function
REQ-014 SHALL implement the FSM states IDLE, STREAM and DONE.
REQ-015 SHALL, in IDLE with en=1 and start=1, register all nine row inputs on that edge, set col=0 and enter STREAM.
REQ-016 SHALL assert win_valid=1 in STREAM only, starting in the cycle after start (latency 1).
REQ-017 SHALL pack each window as {row0[c],row0[c+1],row0[c+2],row1[c],row1[c+1],row1[c+2],row2[c],row2[c+1],row2[c+2]}, where c=col, the MSB-first pixels come from the captured copy, and the window is driven combinationally from col.
REQ-018 SHALL treat a transfer as win_valid & win_ready at a rising edge; col increments by 1 per transfer.
REQ-019 SHALL hold col, the windows and win_valid stable while win_valid=1 and win_ready=0.
REQ-020 SHALL, on a transfer with col=ROW_PIX-3 (415), enter DONE; col wraps to 0 and win_valid falls on the same edge.
REQ-021 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE.
REQ-022 SHALL ignore start in STREAM and DONE; the captured rows are not overwritten.
REQ-023 SHALL emit exactly ROW_PIX-2 (416) windows per start, with no skipped or repeated columns.
REQ-024 SHALL drive busy=1 in STREAM and DONE, and busy=0 in IDLE.
REQ-025 SHALL, when en=0 at a rising edge, go to IDLE with col=0, win_valid=0, done=0 and the captured rows zeroed, regardless of state; start is ignored in that cycle.

Reset
REQ-026 SHALL, on reset=1, immediately force IDLE, col=0, win_valid=0, busy=0, done=0, the captured rows to 0 and therefore R_win/G_win/B_win=0.
REQ-027 SHALL abort any stream in progress on reset mid-operation and emit no further windows until a new start follows the deassertion of reset.

Verification
REQ-028 SHALL cover this case: R pixel j of row r = (j+r) mod 256, win_ready=1, start pulse -> win_valid rises 1 cycle later; col=0 gives R_win=0x000102_010203_020304; 416 consecutive windows; done pulses 1 cycle after the col=415 transfer.
REQ-029 SHALL cover this case: G rows all 0xFF except pad pixels 0 and 417 = 0x00 -> window col=0 gives G_win=0x00FFFF repeated three times; col=415 gives 0xFFFF00 repeated three times.
REQ-030 SHALL cover this case: win_ready toggled 1,0,0,1 -> col advances only on the ready=1 cycles; the window is unchanged while stalled; the total count is still 416.
REQ-031 SHALL cover this case: start re-pulsed at col=100 with different rows -> it is ignored; the stream continues from the first capture through col=415.
REQ-032 SHALL cover this case: reset asserted at col=200 -> all outputs are 0 immediately; after reset falls, no window appears until start.
REQ-033 SHALL cover this case: en dropped at col=50 -> next edge gives IDLE, win_valid=0, col=0; start with en=1 restarts at col=0.
